// File: rtl/byte_bus_bridge_pkg.sv
// Shared definitions for the byte bus bridge: FSM state encoding, legal
// transaction sizes and a size-legality helper.
package byte_bus_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int unsigned SZ_B = 32'd1;
    localparam int unsigned SZ_H = 32'd2;
    localparam int unsigned SZ_W = 32'd4;
    localparam int unsigned SZ_D = 32'd8;

    // A byte count is legal when it is 1, 2, 4, or 8 on a 64-bit bus.
    function automatic logic size_is_legal(input int unsigned n, input int unsigned bytes);
        return (n == SZ_B) || (n == SZ_H) || (n == SZ_W) ||
               ((n == SZ_D) && (bytes == SZ_D));
    endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder: one base/mask comparator per slave followed
// by a lowest-index priority pick. Kept standalone so other fabrics can reuse it.
module bridge_addr_decode
    import byte_bus_bridge_pkg::*;
#(
    parameter int                        NUM_SLAVES = 8,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK = {NUM_SLAVES{32'h0}}
) (
    input  logic [31:0]            i_addr,
    output logic [NUM_SLAVES-1:0]  o_hit,
    output logic                   o_any_hit
);

    localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

    logic [NUM_SLAVES-1:0] raw_hit_s;

    // Compare the address against every slave window.
    always_comb begin
        raw_hit_s = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            raw_hit_s[k] = ((i_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]);
        end
    end

    // Keep only the lowest set bit so overlapping windows resolve to the lowest index.
    always_comb begin
        o_hit     = raw_hit_s & (~raw_hit_s + ONE);
        o_any_hit = |raw_hit_s;
    end

endmodule

// File: rtl/byte_bus_bridge.sv
// Byte bus bridge: accepts one 1/2/4/8-byte CPU transaction, serialises it
// into byte requests to the decoded slave, assembles read bytes and returns a
// single completion pulse with error status.
module byte_bus_bridge
    import byte_bus_bridge_pkg::*;
#(
    parameter int                        NUM_SLAVES  = 8,
    parameter int                        DATA_W      = 32,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE  = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK  = {NUM_SLAVES{32'h0}},
    parameter int                        TIMEOUT_CYC = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [DATA_W-1:0]              i_bus_data,
    input  logic [31:0]                    i_bus_address,
    input  logic                           i_bus_DV,
    input  logic [$clog2(DATA_W/8):0]      i_bhw,
    input  logic                           i_write_notread,
    output logic                           o_bus_ready,
    output logic                           o_bus_DV,
    output logic                           o_bus_err,
    output logic [DATA_W-1:0]              o_bus_data,
    output logic [NUM_SLAVES-1:0]          o_sub_request,
    output logic                           o_sub_write,
    output logic [31:0]                    o_sub_address,
    output logic [7:0]                     o_sub_data,
    input  logic [8*NUM_SLAVES-1:0]        i_sub_data,
    input  logic [NUM_SLAVES-1:0]          i_sub_DV
);

    localparam int BYTES  = DATA_W / 8;
    localparam int SIZE_W = $clog2(BYTES) + 1;
    localparam int CNT_W  = $clog2(BYTES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC) + 1;
    // The counter is checked before it increments, so comparing against
    // TIMEOUT_CYC-2 lands DONE exactly TIMEOUT_CYC cycles after the request.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [31:0]             addr_q, addr_d;
    logic [SIZE_W-1:0]       size_q, size_d;
    logic                    write_q, write_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    err_q, err_d;

    logic                    ready_q, ready_d;
    logic                    bus_dv_q, bus_dv_d;
    logic                    bus_err_q, bus_err_d;
    logic [DATA_W-1:0]       bus_data_q, bus_data_d;
    logic [NUM_SLAVES-1:0]   sub_req_q, sub_req_d;
    logic                    sub_write_q, sub_write_d;
    logic [31:0]             sub_addr_q, sub_addr_d;
    logic [7:0]              sub_data_q, sub_data_d;

    logic [NUM_SLAVES-1:0]   hit_s;
    logic                    any_hit_s;
    logic                    size_ok_s;
    logic                    last_s;
    logic                    dv_hit_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [7:0]              rd_byte_s;

    bridge_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .i_addr    (addr_q),
        .o_hit     (hit_s),
        .o_any_hit (any_hit_s)
    );

    assign size_ok_s = size_is_legal(32'(size_q), 32'(BYTES));
    assign last_s    = ({1'b0, cnt_q} == (size_q - SIZE_W'(1)));
    assign dv_hit_s  = |(i_sub_DV & sel_q);
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Pick the read byte of the selected slave; sel_q is one-hot so an OR works.
    always_comb begin
        rd_byte_s = 8'h00;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q[k]) begin
                rd_byte_s = rd_byte_s | i_sub_data[8*k +: 8];
            end else begin
                rd_byte_s = rd_byte_s;
            end
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        addr_d      = addr_q;
        size_d      = size_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        sel_d       = sel_q;
        err_d       = err_q;
        bus_data_d  = bus_data_q;
        bus_dv_d    = 1'b0;
        bus_err_d   = 1'b0;
        sub_req_d   = '0;
        sub_write_d = 1'b0;
        sub_addr_d  = sub_addr_q;
        sub_data_d  = sub_data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_bus_DV) begin
                    data_d     = i_bus_data;
                    addr_d     = i_bus_address;
                    size_d     = i_bhw;
                    write_d    = i_write_notread;
                    bus_data_d = '0;
                    cnt_d      = '0;
                    sel_d      = '0;
                    err_d      = 1'b0;
                    state_d    = ST_DECODE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_DECODE: begin
                sel_d = hit_s;
                if (any_hit_s && size_ok_s) begin
                    cnt_d       = '0;
                    tmo_d       = '0;
                    sub_req_d   = hit_s;
                    sub_write_d = write_q;
                    sub_addr_d  = addr_q;
                    sub_data_d  = data_q[7:0];
                    state_d     = ST_REQ;
                end else begin
                    err_d       = 1'b1;
                    bus_dv_d    = 1'b1;
                    bus_err_d   = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_REQ: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (dv_hit_s) begin
                    if (!write_q) begin
                        bus_data_d[{cnt_q, 3'b000} +: 8] = rd_byte_s;
                    end else begin
                        bus_data_d = bus_data_q;
                    end
                    if (last_s) begin
                        bus_dv_d  = 1'b1;
                        bus_err_d = err_q;
                        state_d   = ST_DONE;
                    end else begin
                        // Address wraps modulo 2^32; select stays on the decoded slave.
                        cnt_d       = cnt_inc_s;
                        sub_req_d   = sel_q;
                        sub_write_d = write_q;
                        sub_addr_d  = addr_q + 32'(cnt_inc_s);
                        sub_data_d  = data_q[{cnt_inc_s, 3'b000} +: 8];
                        state_d     = ST_REQ;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    bus_dv_d  = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmo_d     = tmo_q + TMO_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            addr_q      <= 32'h0;
            size_q      <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            sel_q       <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            bus_dv_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_data_q  <= '0;
            sub_req_q   <= '0;
            sub_write_q <= 1'b0;
            sub_addr_q  <= 32'h0;
            sub_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            bus_dv_q    <= bus_dv_d;
            bus_err_q   <= bus_err_d;
            bus_data_q  <= bus_data_d;
            sub_req_q   <= sub_req_d;
            sub_write_q <= sub_write_d;
            sub_addr_q  <= sub_addr_d;
            sub_data_q  <= sub_data_d;
        end
    end

    assign o_bus_ready   = ready_q;
    assign o_bus_DV      = bus_dv_q;
    assign o_bus_err     = bus_err_q;
    assign o_bus_data    = bus_data_q;
    assign o_sub_request = sub_req_q;
    assign o_sub_write   = sub_write_q;
    assign o_sub_address = sub_addr_q;
    assign o_sub_data    = sub_data_q;

endmodule

// File: tb/tb_byte_bus_bridge.sv
// Self-checking bench for byte_bus_bridge: directed scenarios followed by
// randomized transactions, all compared against a transaction-level model.
module tb_byte_bus_bridge;

    localparam int TMO = 16;
    localparam logic [255:0] TB_BASE = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3000_0000, 32'hF000_0000,
                                        32'h2000_0000, 32'h0010_0000, 32'h2000_0000, 32'hFFFF_FFFF};
    localparam logic [255:0] TB_MASK = {32'h0000_0000, 32'h0000_0000, 32'hF000_0000, 32'hF000_0000,
                                        32'hF000_0000, 32'hFFF0_0000, 32'hF000_0000, 32'h0000_0000};

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_bus_data;
    logic [31:0] i_bus_address;
    logic        i_bus_DV;
    logic [2:0]  i_bhw;
    logic        i_write_notread;
    logic        o_bus_ready;
    logic        o_bus_DV;
    logic        o_bus_err;
    logic [31:0] o_bus_data;
    logic [7:0]  o_sub_request;
    logic        o_sub_write;
    logic [31:0] o_sub_address;
    logic [7:0]  o_sub_data;
    logic [63:0] i_sub_data;
    logic [7:0]  i_sub_DV;

    int n_checks = 0;
    int n_fail   = 0;

    // observations of the last transaction
    logic [7:0]  resp [8];
    int          req_cnt;
    logic [7:0]  req_sel  [16];
    logic [31:0] req_addr [16];
    logic        req_wr   [16];
    logic [7:0]  req_dat  [16];
    int          got_cyc;
    logic        got_err;
    logic [31:0] got_data;
    logic        onehot_bad;
    logic        busy_ready;

    byte_bus_bridge #(
        .NUM_SLAVES  (8),
        .DATA_W      (32),
        .SLAVE_BASE  (TB_BASE),
        .SLAVE_MASK  (TB_MASK),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_bus_data      (i_bus_data),
        .i_bus_address   (i_bus_address),
        .i_bus_DV        (i_bus_DV),
        .i_bhw           (i_bhw),
        .i_write_notread (i_write_notread),
        .o_bus_ready     (o_bus_ready),
        .o_bus_DV        (o_bus_DV),
        .o_bus_err       (o_bus_err),
        .o_bus_data      (o_bus_data),
        .o_sub_request   (o_sub_request),
        .o_sub_write     (o_sub_write),
        .o_sub_address   (o_sub_address),
        .o_sub_data      (o_sub_data),
        .i_sub_data      (i_sub_data),
        .i_sub_DV        (i_sub_DV)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address map rule: lowest slave whose masked address equals its base.
    function automatic int exp_slave(input logic [31:0] a);
        for (int k = 0; k < 8; k++) begin
            if ((a & TB_MASK[32*k +: 32]) == TB_BASE[32*k +: 32]) return k;
        end
        return -1;
    endfunction

    // Issue one transaction and act as the slaves until completion (or rst_cyc).
    // Cycle 1 is the first cycle after the accepting edge.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [2:0] n,
                           input logic wr, input int dly, input int stall_after,
                           input logic spur, input int rst_cyc);
        int cyc;
        int cnt_dn;
        int pend_idx;
        logic [7:0] pend_m;
        i_bus_address = a; i_bus_data = d; i_bhw = n; i_write_notread = wr; i_bus_DV = 1'b1;
        req_cnt = 0; got_cyc = -1; got_err = 1'b0; got_data = 32'hDEAD_BEEF;
        onehot_bad = 1'b0; busy_ready = 1'b0;
        pend_m = 8'h00; cnt_dn = 0; pend_idx = 0;
        @(posedge i_clk); #1; cyc = 1;
        // garbage on the bus while busy must be ignored
        i_bus_data = $urandom; i_bus_address = $urandom;
        i_bhw = 3'($urandom); i_write_notread = 1'($urandom);
        while (cyc <= 200) begin
            i_sub_DV = 8'h00;
            i_sub_data = {$urandom, $urandom};
            if (pend_m != 8'h00) begin
                cnt_dn = cnt_dn - 1;
                if (cnt_dn == 0) begin
                    i_sub_DV = pend_m;
                    for (int k = 0; k < 8; k++) begin
                        if (pend_m[k]) i_sub_data[8*k +: 8] = resp[pend_idx];
                    end
                    pend_m = 8'h00;
                end
            end
            if (spur && i_sub_DV == 8'h00) i_sub_DV[5] = 1'b1;
            if (o_bus_ready) busy_ready = 1'b1;
            if (o_bus_DV) begin
                got_cyc = cyc; got_err = o_bus_err; got_data = o_bus_data;
                break;
            end
            if (o_sub_request != 8'h00) begin
                if (!$onehot(o_sub_request)) onehot_bad = 1'b1;
                if (req_cnt < 16) begin
                    req_sel[req_cnt] = o_sub_request; req_addr[req_cnt] = o_sub_address;
                    req_wr[req_cnt] = o_sub_write;    req_dat[req_cnt] = o_sub_data;
                end
                if (req_cnt < stall_after) begin
                    pend_m = o_sub_request; cnt_dn = dly; pend_idx = req_cnt;
                end
                req_cnt++;
            end
            if (cyc == rst_cyc) break;
            @(posedge i_clk); #1; cyc++;
        end
        i_bus_DV = 1'b0;
        i_sub_DV = 8'h00;
    endtask

    // Predict the transaction outcome from the bridge rules and compare.
    task automatic check_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input int n, input logic wr, input int dly, input int stall_after);
        int k, nb, exp_cyc, exp_nreq;
        logic exp_err;
        logic [31:0] exp_data, ea;
        logic [7:0] es;
        k = exp_slave(a);
        exp_data = 32'h0;
        if (k < 0 || !(n == 1 || n == 2 || n == 4)) begin
            exp_err = 1'b1; exp_cyc = 2; exp_nreq = 0; nb = 0;
        end else if (stall_after < n) begin
            exp_err = 1'b1; exp_nreq = stall_after + 1; nb = stall_after;
            exp_cyc = 2 + stall_after * (1 + dly) + TMO;
        end else begin
            exp_err = 1'b0; exp_nreq = n; nb = n; exp_cyc = 2 + n * (1 + dly);
        end
        if (!wr) begin
            for (int j = 0; j < nb; j++) exp_data = exp_data | (32'(resp[j]) << (8 * j));
        end
        chk({tag, ".cycle"}, 64'(got_cyc), 64'(exp_cyc));
        chk({tag, ".err"}, 64'(got_err), 64'(exp_err));
        chk({tag, ".data"}, 64'(got_data), 64'(exp_data));
        chk({tag, ".nreq"}, 64'(req_cnt), 64'(exp_nreq));
        chk({tag, ".ready_busy"}, 64'(busy_ready), 64'h0);
        chk({tag, ".onehot"}, 64'(onehot_bad), 64'h0);
        es = (k >= 0) ? (8'd1 << k) : 8'd0;
        for (int j = 0; j < exp_nreq && j < req_cnt && j < 16; j++) begin
            ea = a + 32'(j);
            chk($sformatf("%s.req%0d_sel", tag, j), 64'(req_sel[j]), 64'(es));
            chk($sformatf("%s.req%0d_addr", tag, j), 64'(req_addr[j]), 64'(ea));
            chk($sformatf("%s.req%0d_wr", tag, j), 64'(req_wr[j]), 64'(wr));
            chk($sformatf("%s.req%0d_data", tag, j), 64'(req_dat[j]), 64'(d[8*j +: 8]));
        end
        @(posedge i_clk); #1;
        chk({tag, ".idle_ready"}, 64'(o_bus_ready), 64'h1);
        chk({tag, ".idle_dv"}, 64'(o_bus_DV), 64'h0);
        chk({tag, ".held_data"}, 64'(o_bus_data), 64'(exp_data));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".ready"}, 64'(o_bus_ready), 64'h1);
        chk({tag, ".dv_err"}, 64'({o_bus_DV, o_bus_err}), 64'h0);
        chk({tag, ".bus_data"}, 64'(o_bus_data), 64'h0);
        chk({tag, ".sub_req_wr"}, 64'({o_sub_request, o_sub_write}), 64'h0);
        chk({tag, ".sub_addr"}, 64'(o_sub_address), 64'h0);
        chk({tag, ".sub_data"}, 64'(o_sub_data), 64'h0);
    endtask

    initial begin
        int szl [10];
        logic [31:0] a, d;
        int n, dly, st, r;
        logic wr;
        szl = '{1, 2, 4, 1, 2, 4, 0, 3, 5, 7};
        i_rst = 1'b1; i_bus_data = 32'h0; i_bus_address = 32'h0; i_bus_DV = 1'b0;
        i_bhw = 3'd0; i_write_notread = 1'b0; i_sub_data = 64'h0; i_sub_DV = 8'h00;
        for (int j = 0; j < 8; j++) resp[j] = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        check_zero_outputs("reset");
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // word write to slave 2
        run_txn(32'h0010_0004, 32'hA1B2_C3D4, 3'd4, 1'b1, 1, 8, 1'b0, 0);
        check_txn("word_wr", 32'h0010_0004, 32'hA1B2_C3D4, 4, 1'b1, 1, 8);

        // half read
        resp[0] = 8'h5A; resp[1] = 8'h3C;
        run_txn(32'h0010_0006, 32'h0, 3'd2, 1'b0, 1, 8, 1'b0, 0);
        check_txn("half_rd", 32'h0010_0006, 32'h0, 2, 1'b0, 1, 8);

        // unmapped byte read
        run_txn(32'h9000_0000, 32'h0, 3'd1, 1'b0, 1, 8, 1'b0, 0);
        check_txn("unmapped", 32'h9000_0000, 32'h0, 1, 1'b0, 1, 8);

        // timeout after the first byte
        resp[0] = 8'h11;
        run_txn(32'h0010_0100, 32'h0, 3'd4, 1'b0, 1, 1, 1'b0, 0);
        check_txn("timeout", 32'h0010_0100, 32'h0, 4, 1'b0, 1, 1);

        // reset during WAIT of the second byte of a word write
        run_txn(32'h0010_0004, 32'hA1B2_C3D4, 3'd4, 1'b1, 1, 8, 1'b0, 5);
        i_rst = 1'b1;
        #1;
        check_zero_outputs("mid_rst");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        resp[0] = 8'h77;
        run_txn(32'h0010_0009, 32'h0, 3'd1, 1'b0, 1, 8, 1'b0, 0);
        check_txn("post_rst", 32'h0010_0009, 32'h0, 1, 1'b0, 1, 8);

        // overlapping windows with a spurious DV from slave 5
        resp[0] = 8'h01; resp[1] = 8'h23; resp[2] = 8'h45; resp[3] = 8'h67;
        run_txn(32'h2000_0010, 32'h0, 3'd4, 1'b0, 3, 8, 1'b1, 0);
        check_txn("overlap", 32'h2000_0010, 32'h0, 4, 1'b0, 3, 8);
        run_txn(32'h2000_0010, 32'h0, 3'd3, 1'b0, 1, 8, 1'b0, 0);
        check_txn("bhw3", 32'h2000_0010, 32'h0, 3, 1'b0, 1, 8);

        // address wrap and slave-boundary crossing
        run_txn(32'hFFFF_FFFE, 32'h1234_5678, 3'd4, 1'b1, 1, 8, 1'b0, 0);
        check_txn("wrap", 32'hFFFF_FFFE, 32'h1234_5678, 4, 1'b1, 1, 8);
        resp[0] = 8'hC1; resp[1] = 8'hC2; resp[2] = 8'hC3; resp[3] = 8'hC4;
        run_txn(32'h001F_FFFE, 32'h0, 3'd4, 1'b0, 2, 8, 1'b0, 0);
        check_txn("cross", 32'h001F_FFFE, 32'h0, 4, 1'b0, 2, 8);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: a = 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
                1: a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
                2: a = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
                3: a = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF);
                default: a = $urandom;
            endcase
            d   = $urandom;
            n   = szl[$urandom_range(0, 9)];
            wr  = 1'($urandom_range(0, 1));
            dly = $urandom_range(1, 3);
            st  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : 8;
            for (int j = 0; j < 8; j++) resp[j] = 8'($urandom);
            run_txn(a, d, 3'(n), wr, dly, st, 1'b0, 0);
            check_txn($sformatf("rnd%0d", t), a, d, n, wr, dly, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
